// File: rtl/word_stream_out.sv
// Drains the 16-word result memory of the byte-packing FSM after `done_in` rises,
// streaming each word on a valid/ready port with a last flag and a running checksum.
module word_stream_out #(
  parameter int N_WORDS    = 16,
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              done_in,
  output logic [ADDR_W-1:0] rd_add,
  input  logic [DATA_W-1:0] rd_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic [DATA_W-1:0] csum,
  output logic              csum_valid
);

  // state  | meaning
  // IDLE   | waiting for a rising edge on done_in
  // FETCH  | issuing reads while the FIFO has credit for them
  // DRAIN  | all reads issued; waiting for the FIFO to empty
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int ISS_W = ADDR_W + 1;
  localparam int ENT_W = DATA_W + 1;

  state_t             state_q, state_d;
  logic               done_q;
  logic [ISS_W-1:0]   issue_q;
  logic [ISS_W-1:0]   ret_q;
  logic [ADDR_W-1:0]  rd_add_q;
  logic               inflight_q;
  logic               inflight_last_q;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic [DATA_W-1:0]  csum_q;
  logic               csum_valid_q;
  logic [ENT_W-1:0]   fifo_mem [FIFO_DEPTH];

  logic               trigger;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic               room;
  logic               last_issue;
  logic               all_returned;
  logic [CNT_W:0]     occ_sum;
  logic [CNT_W:0]     occ_lim;
  logic [ENT_W-1:0]   head;

  logic               issue_en;
  logic               start;
  logic               drain_done;
  logic               busy_c;

  assign trigger      = done_in & ~done_q;
  assign fifo_empty   = (count_q == '0);
  assign push         = inflight_q;
  assign head         = fifo_mem[rd_ptr_q];
  assign pop          = ~fifo_empty & m_ready;
  assign last_issue   = (issue_q == ISS_W'(N_WORDS - 1));
  assign all_returned = (ret_q == ISS_W'(N_WORDS));

  // A word popped this cycle frees its slot in time for a read issued now,
  // so full-rate streaming does not depend on the FIFO depth.
  assign occ_sum = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
  assign occ_lim = (CNT_W+1)'(FIFO_DEPTH) + {{CNT_W{1'b0}}, pop};
  assign room    = (occ_sum < occ_lim);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (trigger) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (room && last_issue) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (all_returned && fifo_empty && !inflight_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    issue_en   = 1'b0;
    start      = 1'b0;
    drain_done = 1'b0;
    busy_c     = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        busy_c = 1'b0;
        start  = trigger;
      end
      S_FETCH: begin
        issue_en = room;
      end
      S_DRAIN: begin
        drain_done = all_returned & fifo_empty & ~inflight_q;
      end
      default: busy_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q          <= 1'b0;
      issue_q         <= '0;
      ret_q           <= '0;
      rd_add_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      csum_q          <= '0;
      csum_valid_q    <= 1'b0;
    end else begin
      done_q          <= done_in;
      inflight_q      <= issue_en;
      inflight_last_q <= issue_en & (rd_add_q == ADDR_W'(N_WORDS - 1));
      csum_valid_q    <= drain_done;
      if (start) begin
        issue_q  <= '0;
        ret_q    <= '0;
        rd_add_q <= '0;
        csum_q   <= '0;
      end else begin
        if (issue_en) begin
          issue_q  <= issue_q + ISS_W'(1);
          rd_add_q <= rd_add_q + ADDR_W'(1);
        end
        if (push) ret_q <= ret_q + ISS_W'(1);
        if (pop) csum_q <= csum_q + head[DATA_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage needs no reset; the head is only exposed while the FIFO holds data.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {inflight_last_q, rd_data};
  end

  assign rd_add     = rd_add_q;
  assign m_valid    = ~fifo_empty;
  assign m_data     = fifo_empty ? '0 : head[DATA_W-1:0];
  assign m_last     = ~fifo_empty & head[DATA_W];
  assign busy       = busy_c;
  assign csum       = csum_q;
  assign csum_valid = csum_valid_q;

endmodule

// File: tb/tb_word_stream_out.sv
// Scoreboard bench for word_stream_out: a registered RAM model feeds the read port,
// expected words are queued at each trigger and compared against observed handshakes.
module tb_word_stream_out;

  localparam int N = 16;

  logic        clk;
  logic        rst_n;
  logic        done_in;
  logic [3:0]  rd_add;
  logic [15:0] rd_data;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_data;
  logic        m_last;
  logic        busy;
  logic [15:0] csum;
  logic        csum_valid;

  word_stream_out #(.N_WORDS(16), .ADDR_W(4), .DATA_W(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .done_in(done_in), .rd_add(rd_add), .rd_data(rd_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .csum(csum), .csum_valid(csum_valid)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int e0 = 0;

  logic [16:0] exp_q[$];
  logic [16:0] rx_q[$];
  int          rx_cyc[$];
  logic [15:0] exp_sum;
  int          hs_count = 0;
  int          cv_count = 0;
  int          cv_cyc = 0;
  logic [15:0] cv_csum = '0;
  int          stab_viol = 0;
  logic        pv = 1'b0, pr = 1'b0, pl = 1'b0;
  logic [15:0] pd = '0;

  logic [15:0] ram [N];

  function automatic logic [15:0] word_of(input int i);
    logic [7:0] hi, lo;
    hi = 8'(4 * i + 1);
    lo = 8'(4 * i + 3);
    return {hi, lo};
  endfunction

  initial begin
    clk = 1'b0;
    for (int i = 0; i < N; i++) ram[i] = word_of(i);
  end
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial rd_data = '0;
  always @(posedge clk) rd_data <= ram[rd_add];

  always @(negedge clk) begin
    if (m_valid && m_ready) begin
      rx_q.push_back({m_last, m_data});
      rx_cyc.push_back(cyc + 1);
      hs_count++;
    end
    if (csum_valid) begin
      cv_count++;
      cv_csum = csum;
      cv_cyc  = cyc;
    end
    if (rst_n && pv && !pr && (!m_valid || m_data !== pd || m_last !== pl)) stab_viol++;
    pv = rst_n & m_valid;
    pr = m_ready;
    pd = m_data;
    pl = m_last;
  end

  task automatic push_exp();
    exp_sum = '0;
    for (int i = 0; i < N; i++) begin
      exp_q.push_back({(i == N - 1), word_of(i)});
      exp_sum = exp_sum + word_of(i);
    end
  endtask

  task automatic pulse_done();
    @(posedge clk); #1;
    done_in = 1'b1;
    e0 = cyc + 1;
    @(posedge clk); #1;
    done_in = 1'b0;
  endtask

  task automatic wait_cv(input int cv0, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (cv_count > cv0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; done_in = 1'b0; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
    checks++; if (rd_add !== 4'd0) begin errors++; $display("FAIL reset_rd_add: got %0d want 0", rd_add); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (csum !== 16'd0) begin errors++; $display("FAIL reset_csum: got %h want 0000", csum); end
    checks++; if (csum_valid !== 1'b0 || m_last !== 1'b0 || m_data !== 16'd0) begin
      errors++; $display("FAIL reset_misc: got cv=%b last=%b data=%h want 0/0/0000", csum_valid, m_last, m_data);
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_basic();
    bit ok;
    int cv0, n;
    logic [16:0] e, r;
    rx_q.delete(); rx_cyc.delete();
    cv0 = cv_count;
    m_ready = 1'b1;
    push_exp();
    pulse_done();
    wait_cv(cv0, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_timeout: got no csum_valid want pulse"); end
    repeat (3) @(posedge clk); #1;
    checks++; if (cv_count - cv0 !== 1) begin errors++; $display("FAIL basic_cv_pulses: got %0d want 1", cv_count - cv0); end
    checks++; if (cv_csum !== exp_sum) begin errors++; $display("FAIL basic_csum: got %h want %h", cv_csum, exp_sum); end
    checks++; if (cv_cyc !== e0 + 19) begin errors++; $display("FAIL basic_cv_time: got E%0d want E19", cv_cyc - e0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end: got %b want 0", busy); end
    n = rx_q.size();
    checks++; if (n !== N) begin errors++; $display("FAIL basic_count: got %0d want %0d", n, N); end
    if (n > 0) begin
      checks++; if (rx_cyc[0] !== e0 + 3) begin errors++; $display("FAIL basic_first_hs: got E%0d want E3", rx_cyc[0] - e0); end
      checks++; if (rx_cyc[n-1] !== e0 + 3 + N - 1) begin errors++; $display("FAIL basic_last_hs: got E%0d want E%0d", rx_cyc[n-1] - e0, 3 + N - 1); end
    end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      e = exp_q.pop_front(); r = rx_q.pop_front();
      checks++; if (r !== e) begin errors++; $display("FAIL basic_word: got last=%b %h want last=%b %h", r[16], r[15:0], e[16], e[15:0]); end
    end
    exp_q.delete(); rx_q.delete(); rx_cyc.delete();
  endtask

  task automatic test_backpressure();
    bit stalled;
    bit fin;
    int cv0, hs0, k, rfreeze, exp_add;
    logic [16:0] e, r;
    logic pat [4];
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    rx_q.delete();
    cv0 = cv_count; hs0 = hs_count;
    stalled = 1'b0; fin = 1'b0; k = 0;
    stab_viol = 0;
    push_exp();
    pulse_done();
    for (int c = 0; c < 600; c++) begin
      if (cv_count > cv0) begin fin = 1'b1; break; end
      if (!stalled && (hs_count - hs0) >= 4) begin
        stalled = 1'b1;
        m_ready = 1'b0;
        repeat (5) @(posedge clk); #1;
        rfreeze = int'(rd_add);
        repeat (5) @(posedge clk); #1;
        exp_add = (hs_count - hs0 + 4) % N;
        checks++; if (int'(rd_add) !== rfreeze) begin errors++; $display("FAIL bp_rd_add_frozen: got %0d want %0d", rd_add, rfreeze); end
        checks++; if (int'(rd_add) !== exp_add) begin errors++; $display("FAIL bp_rd_add_credit: got %0d want %0d", rd_add, exp_add); end
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_held: got %b want 1", m_valid); end
      end else begin
        m_ready = pat[k % 4];
        k++;
        @(posedge clk); #1;
      end
    end
    m_ready = 1'b1;
    checks++; if (!fin) begin errors++; $display("FAIL bp_timeout: got no csum_valid want pulse"); end
    repeat (3) @(posedge clk); #1;
    checks++; if (stab_viol !== 0) begin errors++; $display("FAIL bp_stable: got %0d violations want 0", stab_viol); end
    checks++; if (cv_csum !== exp_sum) begin errors++; $display("FAIL bp_csum: got %h want %h", cv_csum, exp_sum); end
    checks++; if (rx_q.size() !== N) begin errors++; $display("FAIL bp_count: got %0d want %0d", rx_q.size(), N); end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      e = exp_q.pop_front(); r = rx_q.pop_front();
      checks++; if (r !== e) begin errors++; $display("FAIL bp_word: got last=%b %h want last=%b %h", r[16], r[15:0], e[16], e[15:0]); end
    end
    exp_q.delete(); rx_q.delete(); rx_cyc.delete();
  endtask

  task automatic test_level_done();
    int cv0, hs0;
    logic [16:0] e, r;
    rx_q.delete();
    cv0 = cv_count; hs0 = hs_count;
    m_ready = 1'b1;
    push_exp();
    @(posedge clk); #1;
    done_in = 1'b1;
    repeat (100) @(posedge clk);
    #1 done_in = 1'b0;
    repeat (5) @(posedge clk); #1;
    checks++; if (hs_count - hs0 !== N) begin errors++; $display("FAIL level_hs: got %0d want %0d", hs_count - hs0, N); end
    checks++; if (cv_count - cv0 !== 1) begin errors++; $display("FAIL level_cv: got %0d want 1", cv_count - cv0); end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      e = exp_q.pop_front(); r = rx_q.pop_front();
      checks++; if (r !== e) begin errors++; $display("FAIL level_word: got %h want %h", r, e); end
    end
    exp_q.delete(); rx_q.delete(); rx_cyc.delete();
  endtask

  task automatic test_edge_while_busy();
    bit ok;
    int cv0, hs0;
    rx_q.delete();
    cv0 = cv_count; hs0 = hs_count;
    push_exp();
    pulse_done();
    repeat (4) @(posedge clk);
    pulse_done();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_edge_busy: got %b want 1", busy); end
    wait_cv(cv0, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL busy_edge_timeout: got no csum_valid want pulse"); end
    repeat (30) @(posedge clk); #1;
    checks++; if (hs_count - hs0 !== N) begin errors++; $display("FAIL busy_edge_hs: got %0d want %0d", hs_count - hs0, N); end
    checks++; if (cv_count - cv0 !== 1) begin errors++; $display("FAIL busy_edge_cv: got %0d want 1", cv_count - cv0); end
    exp_q.delete(); rx_q.delete(); rx_cyc.delete();
  endtask

  task automatic test_reset_mid_drain();
    bit ok;
    int cv0, hs0;
    logic [16:0] e, r;
    rx_q.delete();
    hs0 = hs_count;
    m_ready = 1'b1;
    push_exp();
    pulse_done();
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (hs_count - hs0 >= 5) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    checks++; if (!ok) begin errors++; $display("FAIL rst_mid_reach5: got %0d handshakes want 5", hs_count - hs0); end
    cv0 = cv_count;
    rst_n = 1'b0;
    #1;
    checks++; if (m_valid !== 1'b0 || m_data !== 16'd0 || m_last !== 1'b0) begin
      errors++; $display("FAIL rst_mid_stream: got v=%b d=%h l=%b want 0/0000/0", m_valid, m_data, m_last);
    end
    checks++; if (busy !== 1'b0 || rd_add !== 4'd0 || csum !== 16'd0 || csum_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid_ctrl: got busy=%b add=%0d csum=%h cv=%b want 0", busy, rd_add, csum, csum_valid);
    end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); r = rx_q.pop_front();
      checks++; if (r !== e) begin errors++; $display("FAIL rst_mid_prefix: got %h want %h", r, e); end
    end
    exp_q.delete(); rx_q.delete(); rx_cyc.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk); #1;
    checks++; if (cv_count !== cv0) begin errors++; $display("FAIL rst_mid_no_cv: got %0d pulses want 0", cv_count - cv0); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_idle: got m_valid=%b want 0", m_valid); end
    push_exp();
    pulse_done();
    wait_cv(cv0, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_mid_restart_timeout: got no csum_valid want pulse"); end
    repeat (2) @(posedge clk); #1;
    checks++; if (rx_q.size() !== N) begin errors++; $display("FAIL rst_mid_count: got %0d want %0d", rx_q.size(), N); end
    checks++; if (cv_csum !== exp_sum) begin errors++; $display("FAIL rst_mid_csum: got %h want %h", cv_csum, exp_sum); end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      e = exp_q.pop_front(); r = rx_q.pop_front();
      checks++; if (r !== e) begin errors++; $display("FAIL rst_mid_word: got %h want %h", r, e); end
    end
    exp_q.delete(); rx_q.delete(); rx_cyc.delete();
  endtask

  task automatic test_back_to_back();
    bit ok;
    int cv0;
    logic [16:0] e, r;
    m_ready = 1'b1;
    for (int run = 0; run < 2; run++) begin
      rx_q.delete();
      cv0 = cv_count;
      push_exp();
      pulse_done();
      checks++; if (csum !== 16'd0) begin errors++; $display("FAIL b2b_csum_clear run%0d: got %h want 0000", run, csum); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy run%0d: got %b want 1", run, busy); end
      wait_cv(cv0, 200, ok);
      checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout run%0d: got no csum_valid want pulse", run); end
      @(posedge clk); #1;
      checks++; if (csum !== exp_sum) begin errors++; $display("FAIL b2b_csum run%0d: got %h want %h", run, csum, exp_sum); end
      checks++; if (rx_q.size() !== N) begin errors++; $display("FAIL b2b_count run%0d: got %0d want %0d", run, rx_q.size(), N); end
      while (exp_q.size() > 0 && rx_q.size() > 0) begin
        e = exp_q.pop_front(); r = rx_q.pop_front();
        checks++; if (r !== e) begin errors++; $display("FAIL b2b_word run%0d: got %h want %h", run, r, e); end
      end
      exp_q.delete(); rx_q.delete(); rx_cyc.delete();
      repeat (10) @(posedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0; done_in = 1'b0; m_ready = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_level_done();
    test_edge_while_busy();
    test_reset_mid_drain();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/word_stream_out.md
# word_stream_out

Downstream drain stage for the byte-packing transfer FSM. When the FSM raises `done`, this block walks the FSM's 16-word result memory through its read port (`rd_add`/`data_out`). It streams every word out on a valid/ready interface with a last flag and a running 16-bit checksum. A small internal FIFO absorbs the one-cycle read latency and downstream backpressure without losing or repeating words.

## Interface
- `N_WORDS`, 16: words drained per transfer; must equal 2^`ADDR_W`
- `ADDR_W`, 4: read address width
- `DATA_W`, 16: word width
- `FIFO_DEPTH`, 4: output FIFO entries, power of two, ≥2

- `clk`  in  1  single clock; all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `done_in`  in  1  transfer-complete level from the FSM
- `rd_add`  out  `ADDR_W`  read address to the FSM memory
- `rd_data`  in  `DATA_W`  FSM `data_out`; holds word at the `rd_add` sampled on the previous rising edge
- `m_valid`  out  1  output word valid
- `m_ready`  in  1  downstream accept
- `m_data`  out  `DATA_W`  output word
- `m_last`  out  1  high with the final word (index `N_WORDS`-1)
- `busy`  out  1  drain in progress
- `csum`  out  `DATA_W`  sum of accepted words mod 2^`DATA_W`
- `csum_valid`  out  1  one-cycle pulse on the edge after the last handshake

## Operation
- Reset: all outputs 0 (`rd_add`=0, `m_valid`=0, `m_data`=0, `m_last`=0, `busy`=0, `csum`=0, `csum_valid`=0). The FIFO is emptied, the state is IDLE, and `done_q`=0.
- Trigger: rising edge of `done_in` (`done_in`=1 and registered `done_q`=0). Level-high `done_in` without a new edge does nothing. An edge while `busy`=1 is ignored.
- States:
  - IDLE: wait for the trigger. On trigger go to FETCH, set `busy`=1, clear `csum`, and clear the issue and return counters.
  - FETCH: issue a read (`rd_add`←issue count) only when FIFO occupancy + reads in flight < `FIFO_DEPTH`. The returning `rd_data` is pushed one edge after its address is sampled. After `N_WORDS` issues go to DRAIN.
  - DRAIN: wait until every issued word has been returned and popped, then go to IDLE, clear `busy`, and pulse `csum_valid`.
- Handshake: a word transfers on an edge where `m_valid`=1 and `m_ready`=1.
  - `m_data` and `m_last` are stable while `m_valid`=1 and `m_ready`=0.
  - `m_valid` never drops without a handshake.
- `m_last`: tagged on the word read from address `N_WORDS`-1 and travels with it through the FIFO.
- Checksum: `csum`←`csum`+`m_data` on each handshake, truncated to `DATA_W`. The final value holds until the next trigger.
- FIFO: full means no new issue. Simultaneous push and pop leaves occupancy unchanged. Pointers wrap modulo `FIFO_DEPTH`. Overflow is impossible by construction; the issue gate guarantees it.
- Address counter wraps from `N_WORDS`-1 to 0, but no issue occurs past `N_WORDS`.
- Async reset mid-drain aborts immediately: the FIFO is flushed and no `csum_valid` pulse is produced. A new `done_in` edge after reset release starts a fresh drain from address 0.

## Timing
- Edge E0 is the first edge that samples `done_in`=1 with `done_q`=0.
- With `m_ready` held at 1:
  - `rd_add`=0 from E1.
  - Word 0 pushed at E2.
  - `m_valid`=1 with word 0 after E2, first handshake at E3.
  - One word per cycle after that.
  - Word `N_WORDS`-1 (with `m_last`) handshakes at E3+`N_WORDS`-1.
  - `csum_valid` is high for one cycle after the following edge, then `busy`=0.
- With `m_ready`=0, reads stop once occupancy plus reads in flight reach `FIFO_DEPTH`. Streaming resumes on the first edge with `m_ready`=1 and no words are lost.
- Latency and throughput are independent of `FIFO_DEPTH` when `m_ready`=1.

## Test plan
- Bench memory: a registered 16×16 RAM model preloaded with word i = {4i+1, 4i+3}.
- Basic drain: RAM preloaded as above, `m_ready`=1, pulse `done_in`. Required: 16 words 0x0103, 0x0507, …, 0x3D3F in order; `m_last` only on 0x3D3F; `csum`=0xF210; one `csum_valid` pulse; first handshake at E3.
- Backpressure: as above with `m_ready` toggling 1,0,0,1 repeating, plus a 10-cycle stall mid-stream. Required: the same 16 words, no duplicates or drops, `m_data` stable while stalled, `rd_add` frozen once the FIFO and in-flight reads reach 4.
- Level `done_in`: hold `done_in`=1 for 100 cycles. Required: exactly one drain of 16 words; a second edge during `busy` is ignored.
- Reset mid-drain: assert `rst_n`=0 after 5 handshakes. Required: all outputs 0 immediately, no `csum_valid`. A fresh `done_in` edge then produces the full 16-word stream from 0x0103.
- Back-to-back: two `done_in` edges separated by idle time. Required: two identical streams, and `csum` restarts from 0 and ends at 0xF210 each time.
